// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit.
//   MD_WIDTH   : default operand width (HI and LO are each this wide)
//   MD_ITER    : Booth / restoring iteration count at the default width
//   md_state_e : control FSM state encoding
package mult_div_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_ITER  = 32;

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      DIV,
      FIX,
      DONE
   } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand / result bundle between the register file and the multiply/divide unit.
//   master : register-file side, drives operands and start pulses
//   slave  : mult_div_unit side, returns busy/done/div_zero and HI/LO
interface mult_div_unit_if
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
);

   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             start_mult;
   logic             start_div;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output a_in, b_in, start_mult, start_div,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  a_in, b_in, start_mult, start_div,
      output busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/mdu_divider.sv
// Restoring signed divider datapath for mult_div_unit.
// Latches operand magnitudes and sign information on load, performs one
// shift/subtract step per asserted step cycle, and presents sign-corrected
// quotient/remainder combinationally for the parent to capture.
//   clk, reset  : clock, asynchronous active-low reset
//   load        : capture a_in (dividend) and b_in (divisor)
//   step        : one restoring iteration
//   quotient    : signed quotient, truncated toward zero
//   remainder   : signed remainder, sign of the dividend
//   div_by_zero : latched divisor is zero
module mdu_divider
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // Magnitude needs WIDTH+1 bits so that the most negative value survives.
   function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
      logic [WIDTH:0] ext;
      ext = {v[WIDTH-1], v};
      return v[WIDTH-1] ? (~ext + 1'b1) : ext;
   endfunction

   logic [WIDTH:0]   divisor;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH:0]   a_mag;
   logic [WIDTH:0]   shifted;
   logic             fits;

   assign a_mag   = magnitude(a_in);
   // The dividend magnitude is shifted out of quo from the top while the
   // quotient bits are shifted in at the bottom.
   assign shifted = {rem, quo[WIDTH-1]};
   assign fits    = (shifted >= divisor);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         divisor <= '0;
         quo     <= '0;
         rem     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else if (load) begin
         divisor <= magnitude(b_in);
         // |a| <= 2^(WIDTH-1), so it fits WIDTH bits as an unsigned value.
         quo     <= a_mag[WIDTH-1:0];
         rem     <= '0;
         neg_q   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
         neg_r   <= a_in[WIDTH-1];
      end else if (step) begin
         // Partial remainder always stays below divisor <= 2^(WIDTH-1).
         rem <= fits ? WIDTH'(shifted - divisor) : shifted[WIDTH-1:0];
         quo <= {quo[WIDTH-2:0], fits};
      end
   end

   // Most-negative / -1 yields quotient magnitude 2^(WIDTH-1), whose raw
   // bit pattern is exactly the wrapped result expected on LO.
   assign quotient    = neg_q ? (~quo + 1'b1) : quo;
   assign remainder   = neg_r ? (~rem + 1'b1) : rem;
   assign div_by_zero = (divisor == '0);

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit feeding the architectural HI/LO
// registers. Radix-2 Booth multiply; restoring divide in mdu_divider.
// Optional divider: define MULT_DIV_DIVIDE_EN to build the DIV/FIX path and
// div_zero; otherwise start_div is ignored and div_zero is tied low.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mult_div_unit_if.slave
//           a_in/b_in      rs/rt operands, latched on an accepted start
//           start_mult/div single-cycle requests (multiply wins if both)
//           busy           operation in progress
//           done           one-cycle pulse, HI/LO (or div_zero) valid
//           div_zero       divisor was zero, valid with done
//           hi/lo          product halves, or remainder/quotient
//
// state | meaning
// IDLE  | waiting for a start request
// MULT  | Booth iterations on {acc, mq, q_m1}
// DIV   | restoring iterations in mdu_divider
// FIX   | sign-corrected quotient/remainder ready
// DONE  | hi/lo updated, done pulse
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);

   localparam int            ITER     = (WIDTH == MD_WIDTH) ? MD_ITER : WIDTH;
   localparam int            CW       = $clog2(ITER + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER);

   md_state_e        state;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH:0]   mcand;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   booth_acc;
   logic [WIDTH-1:0] mq;
   logic             q_m1;

   always_comb begin
      booth_acc = acc;
      case ({mq[0], q_m1})
         2'b01:   booth_acc = acc + mcand;
         2'b10:   booth_acc = acc - mcand;
         default: booth_acc = acc;
      endcase
   end

`ifdef MULT_DIV_DIVIDE_EN
   logic             div_zero_q;
   logic             div_load;
   logic             div_step;
   logic             div_by_zero;
   logic [WIDTH-1:0] div_quo;
   logic [WIDTH-1:0] div_rem;

   assign div_load = (state == IDLE) && !bus.start_mult && bus.start_div;
   assign div_step = (state == DIV) && (cnt != CNT_LAST) && !div_by_zero;

   mdu_divider #(.WIDTH(WIDTH)) u_divider (
      .clk         (clk),
      .reset       (reset),
      .load        (div_load),
      .step        (div_step),
      .a_in        (bus.a_in),
      .b_in        (bus.b_in),
      .quotient    (div_quo),
      .remainder   (div_rem),
      .div_by_zero (div_by_zero)
   );

   assign bus.div_zero = div_zero_q;
`else
   logic unused_start_div;
   assign unused_start_div = bus.start_div;
   assign bus.div_zero     = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         mcand  <= '0;
         acc    <= '0;
         mq     <= '0;
         q_m1   <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
         div_zero_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.start_mult) begin
                  mcand  <= {bus.a_in[WIDTH-1], bus.a_in};
                  acc    <= '0;
                  mq     <= bus.b_in;
                  q_m1   <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= MULT;
               end
`ifdef MULT_DIV_DIVIDE_EN
               else if (bus.start_div) begin
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= DIV;
               end
`endif
            end

            MULT: begin
               // Iterations run on E1..E(ITER); the following edge commits.
               if (cnt == CNT_LAST) begin
                  hi_q   <= acc[WIDTH-1:0];
                  lo_q   <= mq;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  acc  <= {booth_acc[WIDTH], booth_acc[WIDTH:1]};
                  mq   <= {booth_acc[0], mq[WIDTH-1:1]};
                  q_m1 <= mq[0];
                  cnt  <= cnt + 1'b1;
               end
            end

`ifdef MULT_DIV_DIVIDE_EN
            DIV: begin
               if (div_by_zero) begin
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  div_zero_q <= 1'b1;
                  state      <= DONE;
               end else if (cnt == CNT_LAST) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            FIX: begin
               hi_q   <= div_rem;
               lo_q   <= div_quo;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= DONE;
            end
`endif

            DONE: begin
               state <= IDLE;
            end

            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit, valid with or without
// MULT_DIV_DIVIDE_EN. Expected HI/LO come from 64-bit signed arithmetic.
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic reset;
   bit   div_en;

   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
   endfunction

   // SV division truncates toward zero and % takes the dividend's sign.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint la, lb, q, r;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
      return {r[31:0], q[31:0]};
   endfunction

   // Watches n cycles; returns number of done pulses and busy-high cycles.
   task automatic watch(input int n, output int dones, output int busies);
      dones  = 0;
      busies = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         dones  += int'(bus.done);
         busies += int'(bus.busy);
      end
   endtask

   task automatic run_op(input string tag, input bit sm, input bit sd,
                         input logic [31:0] a, input logic [31:0] b, input bit inject);
      int          exp_lat, lat, busy_cyc, dones, busies;
      bit          exp_dz, got_done;
      logic [63:0] r;

      exp_lat = 0;
      exp_dz  = 1'b0;
      if (sm) begin
         r       = ref_mult(a, b);
         exp_hi  = r[63:32];
         exp_lo  = r[31:0];
         exp_lat = 33;
      end else if (sd && div_en) begin
         if (b == 32'd0) begin
            exp_dz  = 1'b1;
            exp_lat = 1;
         end else begin
            r       = ref_div(a, b);
            exp_hi  = r[63:32];
            exp_lo  = r[31:0];
            exp_lat = 34;
         end
      end

      @(negedge clk);
      bus.a_in       = a;
      bus.b_in       = b;
      bus.start_mult = sm;
      bus.start_div  = sd;
      @(posedge clk); #1;
      busy_cyc       = int'(bus.busy);
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      bus.a_in       = $urandom;
      bus.b_in       = $urandom;

      lat      = 0;
      got_done = 1'b0;
      for (int i = 1; i <= 60 && !got_done; i++) begin
         @(posedge clk); #1;
         if (inject && i == 5) begin
            bus.start_div  = 1'b1;
            bus.start_mult = 1'b1;
         end else if (inject && i == 6) begin
            bus.start_div  = 1'b0;
            bus.start_mult = 1'b0;
         end
         if (bus.done) begin
            got_done = 1'b1;
            lat      = i;
            check_val({tag, "_busy_with_done"}, 64'(bus.busy), 64'd0);
            check_val({tag, "_div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
         end else begin
            busy_cyc += int'(bus.busy);
         end
      end
      check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_val({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
      check_val({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      check_val({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));

      watch(40, dones, busies);
      check_val({tag, "_extra_done"}, 64'(dones), 64'd0);
      check_val({tag, "_idle_busy"}, 64'(busies), 64'd0);
      check_val({tag, "_hold"}, {32'(bus.hi), 32'(bus.lo)}, {exp_hi, exp_lo});
   endtask

   initial begin
      int          dones, busies;
      logic [31:0] ra, rb;

`ifdef MULT_DIV_DIVIDE_EN
      div_en = 1'b1;
`else
      div_en = 1'b0;
`endif
      reset          = 1'b0;
      bus.a_in       = '0;
      bus.b_in       = '0;
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;

      repeat (2) @(negedge clk);
      check_val("reset_busy", 64'(bus.busy), 64'd0);
      check_val("reset_done", 64'(bus.done), 64'd0);
      check_val("reset_div_zero", 64'(bus.div_zero), 64'd0);
      check_val("reset_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'd0);
      reset = 1'b1;

      run_op("mul_6x7",   1'b1, 1'b0, 32'd6, 32'd7, 1'b0);
      run_op("mul_m3x5",  1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      run_op("mul_min2",  1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("div_m7_2",  1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("div_min_m1",1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("mul_pre42", 1'b1, 1'b0, 32'd6, 32'd7, 1'b0);
      run_op("div_by0",   1'b0, 1'b1, 32'd100, 32'd0, 1'b0);
      run_op("both_3x4",  1'b1, 1'b1, 32'd3, 32'd4, 1'b0);
      run_op("mul_inject",1'b1, 1'b0, 32'd3, 32'd4, 1'b1);

      for (int k = 0; k < 8; k++) begin
         ra = $urandom;
         rb = $urandom;
         if (k == 3) ra = 32'h8000_0000;
         if (k == 5) rb = 32'hFFFF_FFFF;
         run_op("mul_rand", 1'b1, 1'b0, ra, rb, 1'b0);
      end

      for (int k = 0; k < 10; k++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'($signed($urandom_range(0, 30)) - 15);
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom & 32'h0000_FFFF;
            default: rb = $urandom;
         endcase
         if (k == 4) ra = 32'h8000_0000;
         run_op("div_rand", 1'b0, 1'b1, ra, rb, 1'b0);
      end

      // Reset during a multiply, 10 cycles in, over a nonzero HI/LO.
      run_op("mul_pre_rst", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      @(negedge clk);
      bus.a_in       = 32'd1234;
      bus.b_in       = 32'd5678;
      bus.start_mult = 1'b1;
      @(posedge clk); #1;
      bus.start_mult = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      exp_hi = '0;
      exp_lo = '0;
      check_val("rst_mid_busy", 64'(bus.busy), 64'd0);
      check_val("rst_mid_done", 64'(bus.done), 64'd0);
      check_val("rst_mid_hilo", {32'(bus.hi), 32'(bus.lo)}, {exp_hi, exp_lo});
      @(negedge clk);
      reset = 1'b1;
      watch(50, dones, busies);
      check_val("rst_mid_no_done", 64'(dones), 64'd0);
      check_val("rst_mid_no_busy", 64'(busies), 64'd0);
      check_val("rst_mid_hold", {32'(bus.hi), 32'(bus.lo)}, {exp_hi, exp_lo});

      run_op("mul_after_rst", 1'b1, 1'b0, 32'd6, 32'd7, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
